serial_subtractor: RTL



---
 rtl/arith_pkg.sv | 22 ++
 rtl/half_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared types and helpers for the serial arithmetic library.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Controller states of the bit-serial arithmetic blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: one extra bit so the counter never wraps inside an op
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : half_subtractor
// Description : Combinational one-bit half subtractor (a - b).
// Revision    : 1.0 - initial release
// ============================================================================
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic bout
);

    // Difference bit and borrow when subtracting b from a
    assign diff = a ^ b;
    assign bout = ~a & b;

endmodule : half_subtractor
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit unsigned subtractor, LSB first, with a
//               start/done handshake. diff = a - b, bout = (a < b).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_d_sh;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_d1;
    logic               w_b1;
    logic               w_d;
    logic               w_b2;
    logic               w_bo;
    logic [WIDTH-1:0]   w_d_next;

    // Full-subtract cell: two half subtractors plus an OR on the borrows
    half_subtractor u_hs_xy (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .diff (w_d1),
        .bout (w_b1)
    );

    half_subtractor u_hs_bin (
        .a    (w_d1),
        .b    (r_borrow),
        .diff (w_d),
        .bout (w_b2)
    );

    // Combine the two partial borrows and form the next result shift value
    always_comb begin
        w_bo     = w_b1 | w_b2;
        w_d_next = {w_d, r_d_sh[WIDTH-1:1]};
    end

    // Control FSM and datapath; results publish only on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_d_sh   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_d_sh   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_d_sh   <= w_d_next;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        diff    <= w_d_next;
                        bout    <= w_bo;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs are plain decodes of the registered state
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

endmodule : serial_subtractor
`default_nettype wire
